vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator, successor to the fixed 640x480 controller.
- Produces pixel coordinates, polarity-configurable HS/VS and a display-enable, each delayed to match a configurable downstream pixel pipeline.
- Adds counter hold, line/frame strobes, a frame counter, and a line-prefetch request for the sprite/line-buffer fetch logic.
- Sits between the PLL-derived vga_clk and the renderer/DAC interface.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, asserted level of vga_hs (0 = active-low)
VS_POL, 0, asserted level of vga_vs
PIPE_DLY, 2, downstream pixel pipeline depth; range 0..15
CW, 10, coordinate width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
vga_clk  in  1  pixel clock
reset  in  1  asynchronous, active-high
enable  in  1  1 = counters advance; 0 = counters hold
x_pos  out  CW  current column, 0..H_TOTAL-1
y_pos  out  CW  current line, 0..V_TOTAL-1
active  out  1  undelayed: x_pos<H_ACTIVE && y_pos<V_ACTIVE
line_end  out  1  undelayed: x_pos==H_TOTAL-1 && enable
frame_end  out  1  undelayed: line_end && y_pos==V_TOTAL-1
line_req  out  1  one-cycle prefetch request
req_line  out  CW  line number for line_req; holds value between requests
frame_count  out  8  completed-frame counter, wraps at 255->0
vga_hs  out  1  delayed horizontal sync
vga_vs  out  1  delayed vertical sync
vga_blank  out  1  delayed display enable (1 = visible pixel, 0 = blanked)

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Defaults give 800 x 525.
- Counters:
  - enable=1: x increments each clock.
  - At x==H_TOTAL-1: x goes to 0 and y increments; y goes from V_TOTAL-1 to 0.
  - enable=0: x, y, frame_count hold.
- frame_count increments on each frame_end cycle.
- HS asserted when H_ACTIVE+H_FP <= x <= H_ACTIVE+H_FP+H_SYNC-1 (defaults: 656..751).
- VS asserted when V_ACTIVE+V_FP <= y <= V_ACTIVE+V_FP+V_SYNC-1 (defaults: 490..491). VS is line-based and is not gated on x.
- Delayed outputs:
  - Registered decode of the current x/y, then a PIPE_DLY-stage shift register.
  - Latency from an x_pos/y_pos value to its vga_hs/vga_vs/vga_blank is PIPE_DLY+1 clocks (default 3).
  - The shift register runs regardless of enable, so with counters held the outputs settle to the held position's values after PIPE_DLY+1 clocks.
- line_req:
  - Registered one-cycle pulse in the clock after x_pos==H_ACTIVE (start of hblank) with enable=1.
  - Only issued when next line n = (y==V_TOTAL-1 ? 0 : y+1) satisfies n < V_ACTIVE.
  - req_line = n, updated in the same cycle as line_req.
  - Result: exactly V_ACTIVE requests per frame. With the defaults the last request is for line 0, issued on line 524.
- Polarity: a signal at its asserted level equals its POL parameter; deasserted = ~POL.
- Reset (async assert, sync release):
  - x_pos = 0, y_pos = 0, frame_count = 0.
  - line_req = 0, req_line = 0.
  - All pipeline stages cleared so that vga_hs = ~HS_POL, vga_vs = ~VS_POL, vga_blank = 0.
  - Reset mid-frame aborts the frame with no partial strobes.
  - First valid delayed outputs appear PIPE_DLY+1 clocks after release.
- Combinational outputs (active, line_end, frame_end) decode the registered counters only; no input-to-output combinational path except through enable on line_end/frame_end.

Test Plan:
- Defaults, reset release, run 2 frames:
  - x wraps 799->0 with y+1; y wraps 524->0.
  - vga_hs low for exactly 96 clocks per line, starting 3 clocks after x==656.
  - vga_vs low for 2 lines (y 490..491, delayed 3).
  - frame_count = 2.
- Defaults, blank check: vga_blank==1 exactly when the counter 3 cycles earlier had x<640 && y<480; 307200 visible clocks per frame.
- PIPE_DLY=0, HS_POL=1, VS_POL=1, tiny timing (H 8/2/3/1, V 4/1/1/1):
  - vga_hs high 1 clock after x==10, for 3 clocks.
  - Line period 14, frame 98 clocks.
- enable low for 50 clocks at x=300, y=100:
  - x/y frozen; no line_end/line_req.
  - Outputs stable after 3 clocks.
  - On resume, x continues from 301.
- line_req:
  - Defaults: 480 pulses per frame; req_line sequence 1..479 then 0.
  - First pulse one clock after x==640 on y=0.
  - No pulses while y is 479..523.
- Async reset asserted at x=700, y=491, mid-sync:
  - vga_hs=1, vga_vs=1, vga_blank=0 immediately.
  - Counters 0.
  - After release, the first line_req occurs on line 0 at x==641.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator.
// Free-running x/y raster counters with hold, undelayed position strobes,
// a line-prefetch request for the line-buffer fetch logic, and polarity-
// configurable sync/blank outputs delayed to match the downstream pixel pipe.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIPE_DLY = 2,
  parameter int CW       = 10
) (
  input  logic          vga_clk,
  input  logic          reset,
  input  logic          enable,
  output logic [CW-1:0] x_pos,
  output logic [CW-1:0] y_pos,
  output logic          active,
  output logic          line_end,
  output logic          frame_end,
  output logic          line_req,
  output logic [CW-1:0] req_line,
  output logic [7:0]    frame_count,
  output logic          vga_hs,
  output logic          vga_vs,
  output logic          vga_blank
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic          h_last;
  logic          v_last;
  logic [CW-1:0] next_line;
  logic          req_hit;
  logic          hs_lvl;
  logic          vs_lvl;
  logic          blank_lvl;

  // Stage 0 holds the registered decode; stages 1..PIPE_DLY model the pixel pipe.
  logic [PIPE_DLY:0] hs_pipe;
  logic [PIPE_DLY:0] vs_pipe;
  logic [PIPE_DLY:0] blank_pipe;

  assign h_last    = (x_pos == H_LAST);
  assign v_last    = (y_pos == V_LAST);
  assign active    = (x_pos < H_ACT) && (y_pos < V_ACT);
  assign line_end  = h_last && enable;
  assign frame_end = line_end && v_last;

  // Prefetch targets the line after the current one, wrapping at frame end,
  // and is only requested for visible lines.
  assign next_line = v_last ? '0 : y_pos + 1'b1;
  assign req_hit   = enable && (x_pos == H_ACT) && (next_line < V_ACT);

  // Sync levels already carry their polarity; VS is purely line-based.
  assign hs_lvl    = ((x_pos >= HS_START) && (x_pos <= HS_END)) ? HS_POL : ~HS_POL;
  assign vs_lvl    = ((y_pos >= VS_START) && (y_pos <= VS_END)) ? VS_POL : ~VS_POL;
  assign blank_lvl = active;

  // Raster counters: x wraps into a y step, y wraps at the last line; hold when disabled.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      x_pos <= '0;
      y_pos <= '0;
    end else if (enable) begin
      if (h_last) begin
        x_pos <= '0;
        y_pos <= v_last ? '0 : y_pos + 1'b1;
      end else begin
        x_pos <= x_pos + 1'b1;
      end
    end
  end

  // Completed-frame counter, wraps naturally at 8 bits.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      frame_count <= '0;
    end else if (frame_end) begin
      frame_count <= frame_count + 8'd1;
    end
  end

  // One-cycle prefetch pulse at start of hblank; req_line holds between pulses.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      line_req <= 1'b0;
      req_line <= '0;
    end else begin
      line_req <= req_hit;
      if (req_hit) begin
        req_line <= next_line;
      end
    end
  end

  generate
    if (PIPE_DLY == 0) begin : g_no_pipe
      // Registered decode only; runs regardless of enable.
      always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
          hs_pipe    <= ~HS_POL;
          vs_pipe    <= ~VS_POL;
          blank_pipe <= 1'b0;
        end else begin
          hs_pipe    <= hs_lvl;
          vs_pipe    <= vs_lvl;
          blank_pipe <= blank_lvl;
        end
      end
    end else begin : g_pipe
      // Registered decode followed by the delay line; runs regardless of enable.
      always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
          hs_pipe    <= {(PIPE_DLY+1){~HS_POL}};
          vs_pipe    <= {(PIPE_DLY+1){~VS_POL}};
          blank_pipe <= '0;
        end else begin
          hs_pipe    <= {hs_pipe[PIPE_DLY-1:0], hs_lvl};
          vs_pipe    <= {vs_pipe[PIPE_DLY-1:0], vs_lvl};
          blank_pipe <= {blank_pipe[PIPE_DLY-1:0], blank_lvl};
        end
      end
    end
  endgenerate

  assign vga_hs    = hs_pipe[PIPE_DLY];
  assign vga_vs    = vs_pipe[PIPE_DLY];
  assign vga_blank = blank_pipe[PIPE_DLY];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two scaled instances (active-low with a 2-stage
// pipe, and a tiny active-high raster with no pipe) checked every clock
// against an arithmetic raster model, plus directed hold/reset scenarios.
module tb_vga_timing_gen;

  localparam int ND = 2;
  localparam int HA [ND] = '{32, 8};
  localparam int HF [ND] = '{4, 2};
  localparam int HS [ND] = '{8, 3};
  localparam int HB [ND] = '{4, 1};
  localparam int VA [ND] = '{20, 4};
  localparam int VF [ND] = '{3, 1};
  localparam int VS [ND] = '{2, 1};
  localparam int VB [ND] = '{5, 1};
  localparam int PD [ND] = '{2, 0};
  localparam bit HP [ND] = '{1'b0, 1'b1};
  localparam bit VP [ND] = '{1'b0, 1'b1};

  logic vga_clk = 1'b0;
  logic reset;
  logic en [ND];

  logic [9:0] o_x [ND];
  logic [9:0] o_y [ND];
  logic [9:0] o_req [ND];
  logic [7:0] o_fc [ND];
  logic o_act [ND];
  logic o_le [ND];
  logic o_fe [ND];
  logic o_lreq [ND];
  logic o_hs [ND];
  logic o_vs [ND];
  logic o_blank [ND];

  int n_cmp = 0;
  int n_err = 0;

  // Model state: position is derived from the number of advancing clocks.
  longint t_adv [ND];
  int     hx [ND][4];
  int     hy [ND][4];
  int     n_since [ND];
  bit     e_lreq [ND];
  int     e_req [ND];
  bit     in_rst;

  always #5 vga_clk = ~vga_clk;

  vga_timing_gen #(
    .H_ACTIVE(HA[0]), .H_FP(HF[0]), .H_SYNC(HS[0]), .H_BP(HB[0]),
    .V_ACTIVE(VA[0]), .V_FP(VF[0]), .V_SYNC(VS[0]), .V_BP(VB[0]),
    .HS_POL(HP[0]), .VS_POL(VP[0]), .PIPE_DLY(PD[0]), .CW(10)
  ) u_dut_a (
    .vga_clk(vga_clk), .reset(reset), .enable(en[0]),
    .x_pos(o_x[0]), .y_pos(o_y[0]), .active(o_act[0]),
    .line_end(o_le[0]), .frame_end(o_fe[0]), .line_req(o_lreq[0]),
    .req_line(o_req[0]), .frame_count(o_fc[0]),
    .vga_hs(o_hs[0]), .vga_vs(o_vs[0]), .vga_blank(o_blank[0])
  );

  vga_timing_gen #(
    .H_ACTIVE(HA[1]), .H_FP(HF[1]), .H_SYNC(HS[1]), .H_BP(HB[1]),
    .V_ACTIVE(VA[1]), .V_FP(VF[1]), .V_SYNC(VS[1]), .V_BP(VB[1]),
    .HS_POL(HP[1]), .VS_POL(VP[1]), .PIPE_DLY(PD[1]), .CW(10)
  ) u_dut_b (
    .vga_clk(vga_clk), .reset(reset), .enable(en[1]),
    .x_pos(o_x[1]), .y_pos(o_y[1]), .active(o_act[1]),
    .line_end(o_le[1]), .frame_end(o_fe[1]), .line_req(o_lreq[1]),
    .req_line(o_req[1]), .frame_count(o_fc[1]),
    .vga_hs(o_hs[1]), .vga_vs(o_vs[1]), .vga_blank(o_blank[1])
  );

  function automatic int ht(int d);
    return HA[d] + HF[d] + HS[d] + HB[d];
  endfunction

  function automatic int vt(int d);
    return VA[d] + VF[d] + VS[d] + VB[d];
  endfunction

  function automatic int mx(int d);
    return int'(t_adv[d] % longint'(ht(d)));
  endfunction

  function automatic int my(int d);
    return int'((t_adv[d] / longint'(ht(d))) % longint'(vt(d)));
  endfunction

  function automatic int mfc(int d);
    return int'((t_adv[d] / longint'(ht(d) * vt(d))) % 256);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    in_rst = 1'b1;
    for (int d = 0; d < ND; d++) begin
      t_adv[d]   = 0;
      n_since[d] = 0;
      e_lreq[d]  = 1'b0;
      e_req[d]   = 0;
      for (int k = 0; k < 4; k++) begin
        hx[d][k] = 0;
        hy[d][k] = 0;
      end
    end
  endtask

  // Advance the model by one clock edge using the enables seen at that edge.
  task automatic model_edge();
    int cx, cy, nxt;
    if (in_rst) return;
    for (int d = 0; d < ND; d++) begin
      cx = mx(d);
      cy = my(d);
      for (int k = 3; k > 0; k--) begin
        hx[d][k] = hx[d][k-1];
        hy[d][k] = hy[d][k-1];
      end
      hx[d][0] = cx;
      hy[d][0] = cy;
      if (n_since[d] < 100) n_since[d]++;
      nxt = (cy + 1) % vt(d);
      e_lreq[d] = en[d] && (cx == HA[d]) && (nxt < VA[d]);
      if (e_lreq[d]) e_req[d] = nxt;
      if (en[d]) t_adv[d]++;
    end
  endtask

  task automatic check_all();
    int cx, cy, px, py;
    bit ehs, evs, ebl, ele;
    string nm;
    for (int d = 0; d < ND; d++) begin
      nm = (d == 0) ? "a" : "b";
      cx = mx(d);
      cy = my(d);
      ele = (cx == ht(d) - 1) && en[d];
      if (n_since[d] >= PD[d] + 1) begin
        px  = hx[d][PD[d]];
        py  = hy[d][PD[d]];
        ehs = ((px >= HA[d] + HF[d]) && (px < HA[d] + HF[d] + HS[d])) ? HP[d] : ~HP[d];
        evs = ((py >= VA[d] + VF[d]) && (py < VA[d] + VF[d] + VS[d])) ? VP[d] : ~VP[d];
        ebl = (px < HA[d]) && (py < VA[d]);
      end else begin
        ehs = ~HP[d];
        evs = ~VP[d];
        ebl = 1'b0;
      end
      chk({nm, "_x"}, 64'(o_x[d]), 64'(cx));
      chk({nm, "_y"}, 64'(o_y[d]), 64'(cy));
      chk({nm, "_active"}, 64'(o_act[d]), 64'((cx < HA[d]) && (cy < VA[d])));
      chk({nm, "_line_end"}, 64'(o_le[d]), 64'(ele));
      chk({nm, "_frame_end"}, 64'(o_fe[d]), 64'(ele && (cy == vt(d) - 1)));
      chk({nm, "_line_req"}, 64'(o_lreq[d]), 64'(e_lreq[d]));
      chk({nm, "_req_line"}, 64'(o_req[d]), 64'(e_req[d]));
      chk({nm, "_frame_count"}, 64'(o_fc[d]), 64'(mfc(d)));
      chk({nm, "_hs"}, 64'(o_hs[d]), 64'(ehs));
      chk({nm, "_vs"}, 64'(o_vs[d]), 64'(evs));
      chk({nm, "_blank"}, 64'(o_blank[d]), 64'(ebl));
    end
  endtask

  task automatic tick();
    @(posedge vga_clk);
    model_edge();
    @(negedge vga_clk);
    check_all();
  endtask

  initial begin
    int blank_cnt, lreq_cnt, cnt;
    int fe_t [2];
    int le_t [2];
    int fe_n, le_n;
    bit found;

    reset = 1'b1;
    en[0] = 1'b0;
    en[1] = 1'b0;
    model_reset();
    repeat (3) tick();
    reset  = 1'b0;
    in_rst = 1'b0;

    // Two full frames of instance a with both instances free running.
    en[0] = 1'b1;
    en[1] = 1'b1;
    blank_cnt = 0;
    lreq_cnt  = 0;
    fe_n = 0;
    le_n = 0;
    for (int i = 0; i < 2 * ht(0) * vt(0); i++) begin
      tick();
      if (o_blank[0] === 1'b1) blank_cnt++;
      if (o_lreq[0] === 1'b1) lreq_cnt++;
      if (o_fe[1] === 1'b1 && fe_n < 2) begin fe_t[fe_n] = i; fe_n++; end
      if (o_le[1] === 1'b1 && le_n < 2) begin le_t[le_n] = i; le_n++; end
    end
    chk("a_visible_clocks", 64'(blank_cnt), 64'(2 * HA[0] * VA[0]));
    chk("a_line_reqs", 64'(lreq_cnt), 64'(2 * VA[0]));
    chk("a_frames_done", 64'(o_fc[0]), 64'd2);
    chk("b_frame_ends_seen", 64'(fe_n), 64'd2);
    chk("b_line_ends_seen", 64'(le_n), 64'd2);
    if (fe_n == 2) chk("b_frame_period", 64'(fe_t[1] - fe_t[0]), 64'd98);
    if (le_n == 2) chk("b_line_period", 64'(le_t[1] - le_t[0]), 64'd14);

    // Random enable pattern on both instances.
    for (int i = 0; i < 3000; i++) begin
      en[0] = ($urandom_range(0, 3) != 0);
      en[1] = ($urandom_range(0, 3) != 0);
      tick();
    end

    // Hold instance a mid-line for 50 clocks, then resume.
    en[0] = 1'b1;
    en[1] = 1'b1;
    cnt = 0;
    while (!(mx(0) == 30 && my(0) == 10) && cnt < 4000) begin
      tick();
      cnt++;
    end
    chk("hold_reached", 64'(mx(0) == 30 && my(0) == 10), 64'd1);
    en[0] = 1'b0;
    repeat (50) tick();
    chk("hold_x", 64'(o_x[0]), 64'd30);
    chk("hold_y", 64'(o_y[0]), 64'd10);
    en[0] = 1'b1;
    tick();
    chk("resume_x", 64'(o_x[0]), 64'd31);

    // Asynchronous reset in the middle of both sync pulses of instance a.
    cnt = 0;
    while (!(mx(0) == 40 && my(0) == 23) && cnt < 4000) begin
      tick();
      cnt++;
    end
    chk("sync_reached", 64'(mx(0) == 40 && my(0) == 23), 64'd1);
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_a_hs", 64'(o_hs[0]), 64'd1);
    chk("rst_a_vs", 64'(o_vs[0]), 64'd1);
    chk("rst_a_blank", 64'(o_blank[0]), 64'd0);
    chk("rst_a_x", 64'(o_x[0]), 64'd0);
    chk("rst_a_y", 64'(o_y[0]), 64'd0);
    chk("rst_b_hs", 64'(o_hs[1]), 64'd0);
    chk("rst_b_vs", 64'(o_vs[1]), 64'd0);
    check_all();
    repeat (2) tick();
    reset  = 1'b0;
    in_rst = 1'b0;
    cnt = 0;
    found = 1'b0;
    while (!found && cnt < 200) begin
      tick();
      cnt++;
      if (o_lreq[0] === 1'b1) found = 1'b1;
    end
    chk("first_req_seen", 64'(found), 64'd1);
    chk("first_req_x", 64'(o_x[0]), 64'(HA[0] + 1));
    chk("first_req_y", 64'(o_y[0]), 64'd0);
    chk("first_req_line", 64'(o_req[0]), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
